csr_file: RTL and testbench

- Machine-mode CSR storage and execute unit. It is the consumer of the decoded CSR parameters (read_enable, write_enable, input_select, write_func) produced in writeback.
- Performs the atomic read-modify-write for CSRRW/CSRRS/CSRRC and the immediate variants, owns the mcycle/minstret counters, and returns the old CSR value to the register writeback path through a valid/ready handshake.

---
 rtl/csr_file.sv | 153 +++++++++++++++
 tb/tb_csr_file.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR storage and read-modify-write execute unit with valid/ready request/response.
// Optional mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_file #(
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] RESET_MEPC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] csr_addr,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [1:0]  write_func,
    input  logic        input_select,
    input  logic [31:0] rs1_value,
    input  logic [4:0]  uimm,
    input  logic        instr_retire,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_illegal
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state;
    logic [31:0] mscratch;
    logic [31:2] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;

    logic [31:0] src;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        addr_hit;
    logic        illegal;
    logic        active;
    logic        accept;
    logic        do_write;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;
`else
    logic        unused_retire;
    assign unused_retire = instr_retire;
`endif

    assign src      = input_select ? {27'b0, uimm} : rs1_value;
    assign active   = (write_func != 2'b00);
    assign accept   = (state == IDLE) && req_valid;
    assign illegal  = !addr_hit || (write_enable && (csr_addr[11:10] == 2'b11));
    assign do_write = accept && active && write_enable && !illegal;

    always_comb begin
        old_val  = '0;
        addr_hit = 1'b1;
        case (csr_addr)
            12'h340: old_val = mscratch;
            12'h341: old_val = {mepc, 2'b00};
            12'h342: old_val = mcause;
            12'h343: old_val = mtval;
            12'hF14: old_val = HART_ID;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: old_val = mcycle[31:0];
            12'hB80, 12'hC80: old_val = mcycle[63:32];
            12'hB02, 12'hC02: old_val = minstret[31:0];
            12'hB82, 12'hC82: old_val = minstret[63:32];
`endif
            default: addr_hit = 1'b0;
        endcase
    end

    always_comb begin
        new_val = old_val;
        case (write_func)
            2'b01:   new_val = src;
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_illegal <= 1'b0;
            mscratch    <= '0;
            mepc        <= RESET_MEPC[31:2];
            mcause      <= '0;
            mtval       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state       <= RESP;
                        req_ready   <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_illegal <= active && illegal;
                        rsp_rdata   <= (active && !illegal && read_enable) ? old_val : '0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (do_write) begin
                case (csr_addr)
                    12'h340: mscratch <= new_val;
                    12'h341: mepc     <= new_val[31:2];
                    12'h342: mcause   <= new_val;
                    12'h343: mtval    <= new_val;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    // A CSR write to either half replaces that cycle's increment for the whole counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (do_write && csr_addr == 12'hB00)
                mcycle <= {mcycle[63:32], new_val};
            else if (do_write && csr_addr == 12'hB80)
                mcycle <= {new_val, mcycle[31:0]};
            else
                mcycle <= mcycle + 64'd1;

            if (do_write && csr_addr == 12'hB02)
                minstret <= {minstret[63:32], new_val};
            else if (do_write && csr_addr == 12'hB82)
                minstret <= {new_val, minstret[31:0]};
            else
                minstret <= minstret + {63'd0, instr_retire};
        end
    end
`endif

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed test-plan steps followed by randomized requests
// checked against a behavioural CSR model.
module tb_csr_file;

    localparam logic [31:0] HART  = 32'h0000_0007;
    localparam logic [31:0] RMEPC = 32'h8000_0003;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] csr_addr = '0;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [1:0]  write_func = 2'b00;
    logic        input_select = 1'b0;
    logic [31:0] rs1_value = '0;
    logic [4:0]  uimm = '0;
    logic        instr_retire = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;

    csr_file #(.HART_ID(HART), .RESET_MEPC(RMEPC)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .csr_addr(csr_addr), .read_enable(read_enable), .write_enable(write_enable),
        .write_func(write_func), .input_select(input_select),
        .rs1_value(rs1_value), .uimm(uimm), .instr_retire(instr_retire),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    int unsigned compared = 0;
    int unsigned mismatched = 0;

    logic [31:0] m_scratch, m_epc, m_cause, m_tval;
    logic [63:0] m_cycle, m_instret;
    logic        cyc_wr, ins_wr;
    logic [63:0] cyc_val, ins_val;

    logic [11:0] addr_pool [16] = '{12'h340, 12'h341, 12'h342, 12'h343, 12'hB00, 12'hB80,
                                    12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
                                    12'hF14, 12'h7C0, 12'h000, 12'hFFF};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scratch = '0; m_epc = RMEPC & ~32'd3; m_cause = '0; m_tval = '0;
        m_cycle = '0; m_instret = '0; cyc_wr = 1'b0; ins_wr = 1'b0;
        cyc_val = '0; ins_val = '0;
    endtask

    function automatic void model_read(input logic [11:0] a, output logic ok, output logic [31:0] v);
        ok = 1'b1;
        v  = '0;
        case (a)
            12'h340: v = m_scratch;
            12'h341: v = m_epc;
            12'h342: v = m_cause;
            12'h343: v = m_tval;
            12'hF14: v = HART;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: v = m_cycle[31:0];
            12'hB80, 12'hC80: v = m_cycle[63:32];
            12'hB02, 12'hC02: v = m_instret[31:0];
            12'hB82, 12'hC82: v = m_instret[63:32];
`endif
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h340: m_scratch = v;
            12'h341: m_epc = v & ~32'd3;
            12'h342: m_cause = v;
            12'h343: m_tval = v;
            12'hB00: begin cyc_wr = 1'b1; cyc_val = {m_cycle[63:32], v}; end
            12'hB80: begin cyc_wr = 1'b1; cyc_val = {v, m_cycle[31:0]}; end
            12'hB02: begin ins_wr = 1'b1; ins_val = {m_instret[63:32], v}; end
            12'hB82: begin ins_wr = 1'b1; ins_val = {v, m_instret[31:0]}; end
            default: ;
        endcase
    endtask

    // One clock edge; counters advance unless a write landed on this edge.
    task automatic tick(input logic retire);
        instr_retire = retire;
        @(posedge clk);
        #1;
        m_cycle   = cyc_wr ? cyc_val : m_cycle + 64'd1;
        m_instret = ins_wr ? ins_val : m_instret + 64'(retire);
        cyc_wr = 1'b0;
        ins_wr = 1'b0;
        instr_retire = 1'b0;
    endtask

    task automatic op(input logic [11:0] a, input logic re, input logic we, input logic [1:0] fn,
                      input logic sel, input logic [31:0] rs1, input logic [4:0] imm,
                      input int unsigned hold, input logic retire, input logic reset_in_resp,
                      output logic [31:0] got);
        logic        ok, ill;
        logic [31:0] old, src, nv, exp_rd;
        check("req_ready_idle", 64'(req_ready), 64'(1));
        csr_addr = a; read_enable = re; write_enable = we; write_func = fn;
        input_select = sel; rs1_value = rs1; uimm = imm; req_valid = 1'b1;
        model_read(a, ok, old);
        src = sel ? {27'b0, imm} : rs1;
        ill = (fn != 2'b00) && (!ok || (we && a[11:10] == 2'b11));
        exp_rd = ((fn != 2'b00) && !ill && re) ? old : 32'd0;
        case (fn)
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            2'b11:   nv = old & ~src;
            default: nv = old;
        endcase
        if (fn != 2'b00 && we && !ill) model_write(a, nv);
        tick(retire);
        req_valid = 1'b0;
        csr_addr = 12'($urandom); rs1_value = $urandom; write_func = 2'($urandom);
        got = rsp_rdata;
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("req_ready_resp", 64'(req_ready), 64'(0));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check("rsp_illegal", 64'(rsp_illegal), 64'(ill));
        if (reset_in_resp) begin
            reset_n = 1'b0;
            #1;
            check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            check("rst_req_ready", 64'(req_ready), 64'(1));
            check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
            repeat (2) @(posedge clk);
            #1;
            reset_n = 1'b1;
            model_reset();
            return;
        end
        rsp_ready = 1'b0;
        for (int unsigned i = 0; i < hold; i++) begin
            tick(retire);
            check("hold_valid", 64'(rsp_valid), 64'(1));
            check("hold_rdata", 64'(rsp_rdata), 64'(exp_rd));
            check("hold_req_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        tick(retire);
        rsp_ready = 1'b0;
        check("rsp_valid_done", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        logic [31:0] got;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'(1));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("reset_rsp_illegal", 64'(rsp_illegal), 64'(0));
        reset_n = 1'b1;

        op(12'h340, 1, 1, 2'b01, 0, 32'hDEADBEEF, 5'd0, 0, 0, 0, got);
        check("csrrw_old", 64'(got), 64'h0);
        op(12'h340, 1, 0, 2'b10, 0, 32'h0, 5'd0, 0, 0, 0, got);
        check("csrrs_read", 64'(got), 64'hDEADBEEF);

        op(12'h340, 1, 1, 2'b01, 0, 32'hF0F0F0F0, 5'd0, 0, 0, 0, got);
        op(12'h340, 1, 1, 2'b11, 1, 32'h0, 5'h0F, 0, 0, 0, got);
        check("csrrci_old", 64'(got), 64'hF0F0F0F0);
        op(12'h340, 1, 1, 2'b10, 1, 32'h0, 5'h1F, 0, 0, 0, got);
        check("csrrsi_old", 64'(got), 64'hF0F0F0F0);
        op(12'h340, 1, 0, 2'b10, 0, 32'h0, 5'd0, 0, 0, 0, got);
        check("mscratch_after_rsi", 64'(got), 64'hF0F0F0FF);

        op(12'h341, 1, 1, 2'b01, 0, 32'h00001003, 5'd0, 0, 0, 0, got);
        check("mepc_reset", 64'(got), 64'h80000000);
        op(12'h341, 1, 0, 2'b10, 0, 32'h0, 5'd0, 0, 0, 0, got);
        check("mepc_align", 64'(got), 64'h00001000);

        op(12'hC00, 1, 1, 2'b01, 0, 32'h12345678, 5'd0, 0, 0, 0, got);
        op(12'h7C0, 1, 0, 2'b10, 0, 32'h0, 5'd0, 0, 0, 0, got);
        op(12'hF14, 1, 0, 2'b10, 0, 32'h0, 5'd0, 0, 0, 0, got);
        check("mhartid", 64'(got), 64'(HART));
        op(12'hC00, 1, 0, 2'b10, 0, 32'h0, 5'd0, 0, 0, 0, got);
        op(12'h342, 1, 1, 2'b00, 0, 32'hFFFFFFFF, 5'd0, 0, 0, 0, got);
        op(12'h342, 1, 0, 2'b10, 0, 32'h0, 5'd0, 0, 0, 0, got);
        check("func_none_no_effect", 64'(got), 64'h0);

`ifdef CSR_COUNTERS_EN
        op(12'hB80, 0, 1, 2'b01, 0, 32'h0, 5'd0, 0, 0, 0, got);
        op(12'hB00, 0, 1, 2'b01, 0, 32'hFFFFFFFF, 5'd0, 0, 0, 0, got);
        op(12'hB80, 1, 0, 2'b10, 0, 32'h0, 5'd0, 0, 0, 0, got);
        check("mcycleh_carry", 64'(got), 64'h1);
        op(12'hB02, 0, 1, 2'b01, 0, 32'h00000100, 5'd0, 0, 1, 0, got);
        op(12'hB02, 1, 0, 2'b10, 0, 32'h0, 5'd0, 0, 0, 0, got);
        check("minstret_collision", 64'(got), 64'h101);
`endif

        op(12'h343, 1, 1, 2'b01, 0, 32'hA5A5A5A5, 5'd0, 5, 0, 0, got);
        op(12'h343, 1, 0, 2'b10, 0, 32'h0, 5'd0, 2, 0, 1, got);
        op(12'h340, 1, 0, 2'b10, 0, 32'h0, 5'd0, 0, 0, 0, got);
        check("mscratch_after_reset", 64'(got), 64'h0);

        for (int i = 0; i < 300; i++) begin
            op(addr_pool[$urandom_range(0, 15)], 1'($urandom), 1'($urandom), 2'($urandom),
               1'($urandom), $urandom, 5'($urandom), $urandom_range(0, 2), 1'($urandom), 0, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
